mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM that sequences the shared MIPS datapath: one memory port, one ALU, the register file and the PC/IR/ALUOut registers. It decodes opcode/func from the instruction register and drives per-state enables and mux selects. It supports the same instruction set as the single-cycle control unit: R-type add/sub/and/or/xor/nor/slt/sltu/sll/srl/jr, addi/andi/ori/xori/slti/sltiu/lui/lw/sw/beq/bne, j and jal. A ready handshake on the memory port stalls the sequence.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready is ignored (single-cycle memory).
TRAP_HALT, 0, 1 = an illegal instruction parks the FSM in HALT until reset; 0 = it resumes at FETCH.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
func  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load, branch condition already folded in
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_write  out  1  register file write enable
reg_dst  out  2  write register select: 00 rt, 01 rd, 10 $31
mem_to_reg  out  2  write data select: 00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  2  ALU A select: 00 PC, 01 rs, 10 shamt
alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 imm, 11 sext(imm)<<2
alu_op  out  2  00 add, 01 sub, 10 R-type (use func), 11 I-type (use opcode)
ext_op  out  1  1 sign-extend imm, 0 zero-extend
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  one-cycle pulse in TRAP
state  out  4  current state, for debug

Behaviour:
- Reset (async, rst_n=0): state=FETCH immediately. All write enables and requests are 0 while reset is asserted; all selects are 0.
- Outputs are Moore decodes of the state, plus opcode/func/zero where noted. Any output not listed for a state is 0.
- Reset asserted mid-instruction aborts the instruction. No write enable stays high after the reset edge.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE: alu_src_a=00, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - lw or sw -> MEM_ADDR
  - R-type with func=001000 -> JR
  - other legal R-type -> R_EXEC
  - addi/andi/ori/xori/slti/sltiu/lui -> I_EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else, including an unknown func -> TRAP
- MEM_ADDR: alu_src_a=01, alu_src_b=10, ext_op=1, alu_op=00. Next MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready; instr_done=1 in the completing cycle, then FETCH.
- R_EXEC: alu_src_b=00, alu_op=10. alu_src_a=10 for sll/srl (func 000000/000010), else 01. Next R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next FETCH.
- I_EXEC: alu_src_a=01, alu_src_b=10, alu_op=11. ext_op=1 for addi/slti/sltiu, 0 for andi/ori/xori/lui. Next I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. Next FETCH.
  - pc_write = (beq & zero) | (bne & ~zero).
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1. Next FETCH. The PC still holds PC+4 when the register file samples it.
- JR: pc_write=1, pc_source=11, instr_done=1. Next FETCH.
- TRAP: illegal=1, no writes. Next FETCH, or HALT if TRAP_HALT=1.
- HALT: all outputs 0; exits only on reset.
- Latency with mem_ready constantly 1:
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - beq, bne, j, jal, jr: 3 cycles
  - each wait cycle in a memory state adds one cycle
- When MEM_WAIT_EN=0, memory states are treated as mem_ready=1.

Decomposition:
- Shared package mips_pkg:
  - opcode and func localparams
  - state encoding, 4 bits
  - ALUOp, pc_source, reg_dst and mem_to_reg encodings
  The single-cycle control unit reuses the opcode/func constants.
- One sub-module: mips_ctrl_decode, a combinational opcode/func -> instruction-class and ext_op decoder, used by DECODE and I_EXEC.

Test Plan:
- Reset, then add (op 000000, func 100000), mem_ready=1: states FETCH, DECODE, R_EXEC, R_WB. reg_write=1 and reg_dst=01 only in cycle 4; instr_done pulses in cycle 4.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ: total 7 cycles; mem_read and iord held high; no reg_write until MEM_WB.
- beq (000100): zero=1 -> pc_write=1 with pc_source=01 in BRANCH; repeat with zero=0 -> pc_write=0. bne (000101) gives the inverted result.
- jal (000011): 3 cycles; in JAL, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
- Opcode 111111: illegal pulses for 1 cycle. TRAP_HALT=0 -> next state FETCH. TRAP_HALT=1 -> HALT persists until rst_n=0.
- Assert rst_n=0 asynchronously during MEM_WRITE: mem_write falls before the next clock edge and state=FETCH; after release the first fetch proceeds normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/func values, multicycle state encoding and
// datapath select codes. The single-cycle control unit reuses the opcode/func set.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_TRAP      = 4'd14,
    S_HALT      = 4'd15
  } state_e;

  // Instruction classes produced by the decoder; one class per DECODE target.
  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_JR    = 4'd1,
    CLS_I     = 4'd2,
    CLS_LOAD  = 4'd3,
    CLS_STORE = 4'd4,
    CLS_BEQ   = 4'd5,
    CLS_BNE   = 4'd6,
    CLS_J     = 4'd7,
    CLS_JAL   = 4'd8,
    CLS_ILL   = 4'd9
  } iclass_e;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ITYP = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/func classifier: instruction class, shift flag and
// immediate extension mode.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output iclass_e    iclass_o,
  output logic       is_shift_o,
  output logic       ext_op_o
);

  always_comb begin
    iclass_o   = CLS_ILL;
    is_shift_o = 1'b0;
    ext_op_o   = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (func_i)
          F_JR: iclass_o = CLS_JR;
          F_SLL, F_SRL: begin
            iclass_o   = CLS_R;
            is_shift_o = 1'b1;
          end
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
            iclass_o = CLS_R;
          default: iclass_o = CLS_ILL;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_SLTIU: begin
        iclass_o = CLS_I;
        ext_op_o = 1'b1;
      end
      // Logical immediates and lui take the raw 16 bits.
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: iclass_o = CLS_I;
      OP_LW:   iclass_o = CLS_LOAD;
      OP_SW:   iclass_o = CLS_STORE;
      OP_BEQ:  iclass_o = CLS_BEQ;
      OP_BNE:  iclass_o = CLS_BNE;
      OP_J:    iclass_o = CLS_J;
      OP_JAL:  iclass_o = CLS_JAL;
      default: iclass_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared memory port, ALU, register
// file and PC/IR/ALUOut registers with Moore-decoded enables and selects.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_HALT   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e  state_q, state_d;
  iclass_e iclass;
  logic    is_shift;
  logic    dec_ext_op;
  logic    mem_ok;

  mips_ctrl_decode u_decode (
    .opcode_i   (opcode),
    .func_i     (func),
    .iclass_o   (iclass),
    .is_shift_o (is_shift),
    .ext_op_o   (dec_ext_op)
  );

  // Handshake: a memory state completes in any cycle where mem_ok is high;
  // with MEM_WAIT_EN=0 the memory is taken to answer every cycle.
  assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_ADD;
    ext_op     = 1'b0;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ok) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFS;
        unique case (iclass)
          CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
          CLS_JR:              state_d = S_JR;
          CLS_R:               state_d = S_R_EXEC;
          CLS_I:               state_d = S_I_EXEC;
          CLS_BEQ, CLS_BNE:    state_d = S_BRANCH;
          CLS_J:               state_d = S_JUMP;
          CLS_JAL:             state_d = S_JAL;
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        state_d   = (iclass == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ok) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ok) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = is_shift ? SRCA_SHAMT : SRCA_RS;
        alu_op    = ALUOP_RTYP;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = RDST_RD;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYP;
        ext_op    = dec_ext_op;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS;
        alu_op     = ALUOP_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = ((iclass == CLS_BEQ) && zero) || ((iclass == CLS_BNE) && !zero);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      // PC still holds PC+4 here, so $31 receives the return address.
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RDST_31;
        mem_to_reg = M2R_PC;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_RS;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = TRAP_HALT ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // While reset is held every enable, request and select is forced low.
    if (!rst_n) begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      ext_op     = 1'b0;
      pc_source  = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors queued and
// compared at the falling edge; a second instance exercises TRAP_HALT=1.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic       ext_op;
    logic [1:0] pc_source;
    logic       instr_done, illegal;
  } ov_t;

  localparam int W = $bits(ov_t);

  logic clk, rst_n;
  logic [5:0] opcode, func;
  logic zero, mem_ready;

  logic pw0, io0, mr0, mw0, iw0, rw0, eo0, id0, il0;
  logic [1:0] rd0, mtr0, sa0, sb0, ao0, ps0;
  logic [3:0] st0;
  logic pw1, io1, mr1, mw1, iw1, rw1, eo1, id1, il1;
  logic [1:0] rd1, mtr1, sa1, sb1, ao1, ps1;
  logic [3:0] st1;

  ov_t out0, out1;
  assign out0 = {st0, pw0, io0, mr0, mw0, iw0, rw0, rd0, mtr0, sa0, sb0, ao0, eo0, ps0, id0, il0};
  assign out1 = {st1, pw1, io1, mr1, mw1, iw1, rw1, rd1, mtr1, sa1, sb1, ao1, eo1, ps1, id1, il1};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_h_q[$];
  int total, bad;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pw0), .iord(io0), .mem_read(mr0),
    .mem_write(mw0), .ir_write(iw0), .reg_write(rw0), .reg_dst(rd0),
    .mem_to_reg(mtr0), .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(ao0),
    .ext_op(eo0), .pc_source(ps0), .instr_done(id0), .illegal(il0), .state(st0)
  );

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pw1), .iord(io1), .mem_read(mr1),
    .mem_write(mw1), .ir_write(iw1), .reg_write(rw1), .reg_dst(rd1),
    .mem_to_reg(mtr1), .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(ao1),
    .ext_op(eo1), .pc_source(ps1), .instr_done(id1), .illegal(il1), .state(st1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected-vector builders, one per state, straight from the state table.
  function automatic ov_t z(input state_e s);
    ov_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction
  function automatic ov_t e_fetch(input logic rdy);
    ov_t e = z(S_FETCH);
    e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction
  function automatic ov_t e_decode();
    ov_t e = z(S_DECODE);
    e.alu_src_b = 2'b11;
    return e;
  endfunction
  function automatic ov_t e_mem_addr();
    ov_t e = z(S_MEM_ADDR);
    e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.ext_op = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mem_read();
    ov_t e = z(S_MEM_READ);
    e.mem_read = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mem_wb();
    ov_t e = z(S_MEM_WB);
    e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mem_write(input logic rdy);
    ov_t e = z(S_MEM_WRITE);
    e.mem_write = 1'b1; e.iord = 1'b1; e.instr_done = rdy;
    return e;
  endfunction
  function automatic ov_t e_r_exec(input logic shift);
    ov_t e = z(S_R_EXEC);
    e.alu_src_a = shift ? 2'b10 : 2'b01; e.alu_op = 2'b10;
    return e;
  endfunction
  function automatic ov_t e_r_wb();
    ov_t e = z(S_R_WB);
    e.reg_write = 1'b1; e.reg_dst = 2'b01; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_i_exec(input logic ext);
    ov_t e = z(S_I_EXEC);
    e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_op = 2'b11; e.ext_op = ext;
    return e;
  endfunction
  function automatic ov_t e_i_wb();
    ov_t e = z(S_I_WB);
    e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_branch(input logic take);
    ov_t e = z(S_BRANCH);
    e.alu_src_a = 2'b01; e.alu_op = 2'b01; e.pc_source = 2'b01;
    e.instr_done = 1'b1; e.pc_write = take;
    return e;
  endfunction
  function automatic ov_t e_jump(input state_e s, input logic [1:0] src);
    ov_t e = z(s);
    e.pc_write = 1'b1; e.pc_source = src; e.instr_done = 1'b1;
    if (s == S_JAL) begin
      e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
    end
    return e;
  endfunction
  function automatic ov_t e_trap();
    ov_t e = z(S_TRAP);
    e.illegal = 1'b1;
    return e;
  endfunction

  // Driver: one clock cycle with its expected vector queued, checked mid-cycle.
  task automatic cyc(input ov_t e, input string tag);
    exp_q.push_back(e);
    @(negedge clk);
    check_eq(tag, out0, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input ov_t e, input ov_t eh, input string tag);
    exp_q.push_back(e);
    exp_h_q.push_back(eh);
    @(negedge clk);
    check_eq(tag, out0, exp_q.pop_front());
    check_eq({tag, "_halt"}, out1, exp_h_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; func = fn; zero = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    exp_q.push_back(z(S_FETCH));
    exp_h_q.push_back(z(S_FETCH));
    check_eq(tag, out0, exp_q.pop_front());
    check_eq({tag, "_halt"}, out1, exp_h_q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input string tag);
    logic shift;
    instr(op, fn);
    shift = (fn == 6'b000000) || (fn == 6'b000010);
    cyc(e_fetch(1'b1), {tag, "_fetch"});
    cyc(e_decode(), {tag, "_decode"});
    if (op == 6'b000000) begin
      cyc(e_r_exec(shift), {tag, "_exec"});
      cyc(e_r_wb(), {tag, "_wb"});
    end else begin
      cyc(e_i_exec(op == 6'b001000 || op == 6'b001010 || op == 6'b001011), {tag, "_exec"});
      cyc(e_i_wb(), {tag, "_wb"});
    end
  endtask

  task automatic run_branch(input logic [5:0] op, input logic zf, input logic take, input string tag);
    instr(op, $urandom_range(0, 63));
    cyc(e_fetch(1'b1), {tag, "_fetch"});
    cyc(e_decode(), {tag, "_decode"});
    zero = zf;
    cyc(e_branch(take), {tag, "_branch"});
    zero = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    #12;
    exp_q.push_back(z(S_FETCH));
    check_eq("reset_outputs", out0, exp_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;

    // R-type and I-type ALU instructions
    run_alu(6'b000000, 6'b100000, "add");
    run_alu(6'b000000, 6'b000000, "sll");
    run_alu(6'b000000, 6'b000010, "srl");
    run_alu(6'b000000, 6'b101011, "sltu");
    run_alu(6'b001000, 6'h15, "addi");
    run_alu(6'b001101, 6'h2a, "ori");
    run_alu(6'b001111, 6'h00, "lui");
    run_alu(6'b001011, 6'h07, "sltiu");

    // lw with a stalled fetch and two wait cycles in MEM_READ
    instr(6'b100011, 6'h11);
    mem_ready = 1'b0;
    cyc(e_fetch(1'b0), "lw_fetch_wait");
    mem_ready = 1'b1;
    cyc(e_fetch(1'b1), "lw_fetch");
    cyc(e_decode(), "lw_decode");
    cyc(e_mem_addr(), "lw_addr");
    mem_ready = 1'b0;
    cyc(e_mem_read(), "lw_read_wait1");
    cyc(e_mem_read(), "lw_read_wait2");
    mem_ready = 1'b1;
    cyc(e_mem_read(), "lw_read");
    cyc(e_mem_wb(), "lw_wb");

    // sw with one wait cycle
    instr(6'b101011, 6'h05);
    cyc(e_fetch(1'b1), "sw_fetch");
    cyc(e_decode(), "sw_decode");
    cyc(e_mem_addr(), "sw_addr");
    mem_ready = 1'b0;
    cyc(e_mem_write(1'b0), "sw_write_wait");
    mem_ready = 1'b1;
    cyc(e_mem_write(1'b1), "sw_write");

    // Branches, both zero polarities
    run_branch(6'b000100, 1'b1, 1'b1, "beq_taken");
    run_branch(6'b000100, 1'b0, 1'b0, "beq_not");
    run_branch(6'b000101, 1'b1, 1'b0, "bne_not");
    run_branch(6'b000101, 1'b0, 1'b1, "bne_taken");

    // Jumps
    instr(6'b000010, 6'h3c);
    cyc(e_fetch(1'b1), "j_fetch");
    cyc(e_decode(), "j_decode");
    cyc(e_jump(S_JUMP, 2'b10), "j_jump");
    instr(6'b000011, 6'h01);
    cyc(e_fetch(1'b1), "jal_fetch");
    cyc(e_decode(), "jal_decode");
    cyc(e_jump(S_JAL, 2'b10), "jal_jal");
    instr(6'b000000, 6'b001000);
    cyc(e_fetch(1'b1), "jr_fetch");
    cyc(e_decode(), "jr_decode");
    cyc(e_jump(S_JR, 2'b11), "jr_jr");

    // Unknown func traps; halting variant parks in HALT
    instr(6'b000000, 6'b111111);
    cyc2(e_fetch(1'b1), e_fetch(1'b1), "badfn_fetch");
    cyc2(e_decode(), e_decode(), "badfn_decode");
    cyc2(e_trap(), e_trap(), "badfn_trap");
    cyc2(e_fetch(1'b1), z(S_HALT), "badfn_after");
    do_reset("reset_after_badfn");

    // Illegal opcode 111111
    instr(6'b111111, 6'h00);
    cyc2(e_fetch(1'b1), e_fetch(1'b1), "badop_fetch");
    cyc2(e_decode(), e_decode(), "badop_decode");
    cyc2(e_trap(), e_trap(), "badop_trap");
    cyc2(e_fetch(1'b1), z(S_HALT), "badop_after1");
    cyc2(e_decode(), z(S_HALT), "badop_after2");
    cyc2(e_trap(), z(S_HALT), "badop_after3");
    do_reset("reset_after_badop");

    // Asynchronous reset in the middle of a stalled MEM_WRITE
    instr(6'b101011, 6'h00);
    cyc(e_fetch(1'b1), "swrst_fetch");
    cyc(e_decode(), "swrst_decode");
    cyc(e_mem_addr(), "swrst_addr");
    mem_ready = 1'b0;
    cyc(e_mem_write(1'b0), "swrst_write_wait");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(z(S_FETCH));
    check_eq("swrst_async", out0, exp_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_alu(6'b000000, 6'b100010, "sub_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
